// File: rtl/grid_checker_pkg.sv
// rtl/grid_checker_pkg.sv - shared cell, line-code and state encodings for grid_checker
package grid_checker_pkg;

  localparam int CELL_W    = 2;
  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef logic [CELL_W-1:0] cell_t;

  localparam cell_t CELL_EMPTY   = 2'd0;
  localparam cell_t CELL_P1      = 2'd1;
  localparam cell_t CELL_P2      = 2'd2;
  localparam cell_t CELL_ILLEGAL = 2'd3;

  localparam logic [3:0] LINE_NONE    = 4'd0;
  localparam logic [3:0] LINE_ROW_A   = 4'd1;
  localparam logic [3:0] LINE_ROW_B   = 4'd2;
  localparam logic [3:0] LINE_ROW_C   = 4'd3;
  localparam logic [3:0] LINE_COL_1   = 4'd4;
  localparam logic [3:0] LINE_COL_2   = 4'd5;
  localparam logic [3:0] LINE_COL_3   = 4'd6;
  localparam logic [3:0] LINE_DIAG_DN = 4'd7;
  localparam logic [3:0] LINE_DIAG_UP = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;

  // Illegal cells (3) never win even when all three agree.
  function automatic logic line_match(input cell_t a, input cell_t b, input cell_t c);
    return (a == b) && (b == c) && ((a == CELL_P1) || (a == CELL_P2));
  endfunction

endpackage

// File: rtl/grid_line_select.sv
// rtl/grid_line_select.sv - picks the three snapshot cells that make up line idx
// Cell k (A1..A3, B1..B3, C1..C3 = 0..8) sits at cells_i[2k+1:2k].
module grid_line_select
  import grid_checker_pkg::*;
(
  input  logic [2:0]                  idx_i,
  input  logic [NUM_CELLS*CELL_W-1:0] cells_i,
  output logic [CELL_W-1:0]           cell0_o,
  output logic [CELL_W-1:0]           cell1_o,
  output logic [CELL_W-1:0]           cell2_o
);

  int i0, i1, i2;

  always_comb begin
    i0 = 0;
    i1 = 1;
    i2 = 2;
    case (idx_i)
      3'd0: begin i0 = 0; i1 = 1; i2 = 2; end
      3'd1: begin i0 = 3; i1 = 4; i2 = 5; end
      3'd2: begin i0 = 6; i1 = 7; i2 = 8; end
      3'd3: begin i0 = 0; i1 = 3; i2 = 6; end
      3'd4: begin i0 = 1; i1 = 4; i2 = 7; end
      3'd5: begin i0 = 2; i1 = 5; i2 = 8; end
      3'd6: begin i0 = 0; i1 = 4; i2 = 8; end
      default: begin i0 = 2; i1 = 4; i2 = 6; end
    endcase
    cell0_o = cells_i[i0*CELL_W +: CELL_W];
    cell1_o = cells_i[i1*CELL_W +: CELL_W];
    cell2_o = cells_i[i2*CELL_W +: CELL_W];
  end

endmodule

// File: rtl/grid_checker.sv
// rtl/grid_checker.sv - snapshots the board on start and scans one line per clock for a win or draw
module grid_checker
  import grid_checker_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       start_i,
  input  logic [1:0] grid_a1_i,
  input  logic [1:0] grid_a2_i,
  input  logic [1:0] grid_a3_i,
  input  logic [1:0] grid_b1_i,
  input  logic [1:0] grid_b2_i,
  input  logic [1:0] grid_b3_i,
  input  logic [1:0] grid_c1_i,
  input  logic [1:0] grid_c2_i,
  input  logic [1:0] grid_c3_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] winner_o,
  output logic [3:0] win_line_o,
  output logic       draw_o
);

  localparam int SNAP_W = NUM_CELLS * CELL_W;

  logic [1:0]        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        winner_q, winner_d;
  logic [3:0]        win_line_q, win_line_d;
  logic              draw_q, draw_d;

  logic [SNAP_W-1:0] grid_now;
  logic [1:0]        cell0, cell1, cell2;
  logic              match;
  logic              all_occupied;

  assign grid_now = {grid_c3_i, grid_c2_i, grid_c1_i,
                     grid_b3_i, grid_b2_i, grid_b1_i,
                     grid_a3_i, grid_a2_i, grid_a1_i};

  grid_line_select u_line_select (
    .idx_i   (idx_q),
    .cells_i (snap_q),
    .cell0_o (cell0),
    .cell1_o (cell1),
    .cell2_o (cell2)
  );

  assign match = line_match(cell0, cell1, cell2);

  always_comb begin
    all_occupied = 1'b1;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (snap_q[k*CELL_W +: CELL_W] == CELL_EMPTY) all_occupied = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    winner_d   = winner_q;
    win_line_d = win_line_q;
    draw_d     = draw_q;

    // clear outranks both a new start and an in-flight scan.
    if (clear_i) begin
      state_d    = ST_IDLE;
      idx_d      = 3'd0;
      busy_d     = 1'b0;
      winner_d   = CELL_EMPTY;
      win_line_d = LINE_NONE;
      draw_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            snap_d     = grid_now;
            idx_d      = 3'd0;
            busy_d     = 1'b1;
            winner_d   = CELL_EMPTY;
            win_line_d = LINE_NONE;
            draw_d     = 1'b0;
            state_d    = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (match) begin
            winner_d   = cell0;
            win_line_d = {1'b0, idx_q} + 4'd1;
            draw_d     = 1'b0;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
          end else if (idx_q != 3'(NUM_LINES - 1)) begin
            idx_d = idx_q + 3'd1;
          end else begin
            winner_d   = CELL_EMPTY;
            win_line_d = LINE_NONE;
            draw_d     = all_occupied;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      snap_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      winner_q   <= 2'd0;
      win_line_q <= 4'd0;
      draw_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      winner_q   <= winner_d;
      win_line_q <= win_line_d;
      draw_q     <= draw_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign winner_o   = winner_q;
  assign win_line_o = win_line_q;
  assign draw_o     = draw_q;

endmodule

// File: tb/tb_grid_checker.sv
// tb/tb_grid_checker.sv - scoreboard bench for grid_checker
module tb_grid_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic [1:0] g [9];
  logic       busy, done, draw;
  logic [1:0] winner;
  logic [3:0] win_line;

  grid_checker dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .start_i    (start),
    .grid_a1_i  (g[0]),
    .grid_a2_i  (g[1]),
    .grid_a3_i  (g[2]),
    .grid_b1_i  (g[3]),
    .grid_b2_i  (g[4]),
    .grid_b3_i  (g[5]),
    .grid_c1_i  (g[6]),
    .grid_c2_i  (g[7]),
    .grid_c3_i  (g[8]),
    .busy_o     (busy),
    .done_o     (done),
    .winner_o   (winner),
    .win_line_o (win_line),
    .draw_o     (draw)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int w;
    int l;
    int d;
    int due;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_checks = 0;
  int   n_done = 0;
  int   d0;

  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference: first matching line in code order, else draw if board full.
  function automatic exp_t model(input int base);
    exp_t e;
    int   a, b, c;
    bit   found;
    e.w = 0; e.l = 0; e.d = 0; e.due = base + 8;
    found = 0;
    for (int k = 0; k < 8; k++) begin
      a = int'(g[lines[k][0]]);
      b = int'(g[lines[k][1]]);
      c = int'(g[lines[k][2]]);
      if (!found && a == b && b == c && (a == 1 || a == 2)) begin
        e.w = a; e.l = k + 1; e.due = base + k + 1; found = 1;
      end
    end
    if (!found) begin
      e.d = 1;
      for (int k = 0; k < 9; k++) if (g[k] == 2'd0) e.d = 0;
    end
    return e;
  endfunction

  task automatic set_grid(input int v [9]);
    for (int k = 0; k < 9; k++) g[k] = v[k][1:0];
  endtask

  task automatic pulse_start(input bit expect_result);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_result) sb.push_back(model(cyc));
  endtask

  task automatic wait_drain(input int maxc);
    int k = 0;
    while (sb.size() != 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("winner", int'(winner), mon_e.w);
        chk("win_line", int'(win_line), mon_e.l);
        chk("draw", int'(draw), mon_e.d);
        chk("latency", cyc, mon_e.due);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  initial begin
    for (int k = 0; k < 9; k++) g[k] = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_winner", int'(winner), 0);
    chk("rst_win_line", int'(win_line), 0);
    chk("rst_draw", int'(draw), 0);
    rst_n = 1'b1;
    @(negedge clk);

    set_grid('{1,1,1, 0,0,0, 0,0,0});
    pulse_start(1);
    wait_drain(20);
    chk("row_a_busy_after", int'(busy), 0);

    set_grid('{0,0,2, 0,2,0, 2,0,0});
    pulse_start(1);
    wait_drain(20);
    set_grid('{0,0,0, 0,0,0, 0,0,0});
    repeat (5) @(negedge clk);
    chk("hold_winner", int'(winner), 2);
    chk("hold_win_line", int'(win_line), 8);

    set_grid('{1,2,1, 1,2,2, 2,1,1});
    pulse_start(1);
    wait_drain(20);

    set_grid('{1,1,1, 1,0,0, 1,0,0});
    pulse_start(1);
    set_grid('{0,0,0, 0,0,0, 0,0,0});
    wait_drain(20);

    // Start while busy and grid changes during the scan must both be ignored.
    d0 = n_done;
    set_grid('{1,0,0, 1,0,0, 1,0,0});
    pulse_start(1);
    @(negedge clk);
    set_grid('{0,0,0, 0,0,0, 0,0,0});
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(20);
    repeat (12) @(negedge clk);
    chk("single_done", n_done - d0, 1);

    set_grid('{0,0,0, 3,3,3, 0,0,0});
    pulse_start(1);
    wait_drain(20);

    set_grid('{3,3,3, 3,3,3, 3,3,3});
    pulse_start(1);
    wait_drain(20);

    set_grid('{1,1,1, 0,0,0, 2,2,2});
    pulse_start(1);
    wait_drain(20);

    d0 = n_done;
    set_grid('{0,0,0, 3,3,3, 0,0,0});
    pulse_start(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clear_busy", int'(busy), 0);
    chk("clear_winner", int'(winner), 0);
    chk("clear_win_line", int'(win_line), 0);
    chk("clear_draw", int'(draw), 0);
    repeat (12) @(negedge clk);
    chk("clear_no_done", n_done - d0, 0);

    set_grid('{1,1,1, 0,0,0, 0,0,0});
    pulse_start(1);
    wait_drain(20);
    chk("pre_clear_winner", int'(winner), 1);
    @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    start = 1'b0;
    chk("clear_vs_start_busy", int'(busy), 0);
    chk("clear_vs_start_winner", int'(winner), 0);

    d0 = n_done;
    set_grid('{0,0,2, 0,2,0, 2,0,0});
    pulse_start(0);
    repeat (3) @(posedge clk);
    #2;
    chk("busy_before_rst", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_winner", int'(winner), 0);
    chk("rst_mid_win_line", int'(win_line), 0);
    chk("rst_mid_draw", int'(draw), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_no_done", n_done - d0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
